uart_rx_ctrl: RTL
=================

// Module: uart_rx_ctrl
// PURPOSE
//  Receive controller between uart_rx and the CPU expansion-card bus.
//  - Buffers incoming bytes in a FIFO.
//  - Exposes DATA and STATUS registers to the CPU.
//  - Tracks overflow and raises an interrupt on fill level or idle timeout.
//  - One instance per UART card; drives the card's IRQ line.
// PARAMETERS
//  DEPTH         16     FIFO entries; power of two, 2..16
//  IRQ_LEVEL     8      fill level (1..DEPTH) at which o_irq asserts
//  TIMEOUT_CLKS  34720  idle clocks with FIFO non-empty before timeout flag (~4 chars @115200)
// PORTS
//  i_clk      in   1  system clock
//  i_reset    in   1  synchronous reset, active-high
//  i_rxValid  in   1  one-cycle strobe from uart_rx: byte received
//  i_rxData   in   8  received byte, valid with i_rxValid
//  i_addr     in   1  register select: 0=DATA, 1=STATUS/CTRL
//  i_read     in   1  one-cycle read strobe
//  i_write    in   1  one-cycle write strobe
//  i_wdata    in   8  write data
//  o_rdata    out  8  read data, registered
//  o_irq      out  1  level interrupt to CPU
// BEHAVIOUR
//  Interface:
//  - One clock, i_clk. Reset i_reset is synchronous, active-high.
//  - Reset (also mid-operation) clears: FIFO pointers, count=0, overflow=0, timeout=0,
//    idle counter=0, o_rdata=8'h00, o_irq=0. FIFO RAM contents are don't-care.
//  Registers:
//  - STATUS read value = {overflow, timeout, full, count[4:0]}.
//  - count is 0..DEPTH, 5 bits wide; full = (count==DEPTH).
//  - Read latency: o_rdata updates on the clock edge after i_read is sampled;
//    it holds its value until the next read.
//  - DATA read, FIFO non-empty: o_rdata=head byte; pop; count-1.
//  - DATA read, FIFO empty: o_rdata=8'h00; no state change.
//  - CTRL write (i_addr=1):
//    - i_wdata[7]=1 clears overflow.
//    - i_wdata[0]=1 flushes: count=0, pointers equal, timeout=0.
//    - Other bits are ignored.
//  - Write with i_addr=0 is ignored. i_read and i_write together: the read wins.
//  FIFO and arbitration (per cycle):
//  - Push when i_rxValid=1 and the FIFO is not full.
//  - Push when full with no pop this cycle: byte dropped, overflow set (sticky).
//  - Push and pop in the same cycle when full: both occur, count unchanged,
//    overflow stays unchanged.
//  - Push and pop in the same cycle when empty: the read returns 8'h00.
//    The push still occurs, count becomes 1.
//  - Flush and push in the same cycle: flush wins, the byte is discarded,
//    no overflow is set.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//  Idle timeout:
//  - idle counter resets to 0 on any push, any pop, or when count==0.
//    Otherwise it increments, saturating at TIMEOUT_CLKS.
//  - Timeout flag sets when the idle counter reaches TIMEOUT_CLKS-1 and count>0.
//  - Timeout flag clears on pop, flush or reset.
//  Interrupt:
//  - o_irq is registered: o_irq = (count>=IRQ_LEVEL) | timeout | overflow,
//    evaluated from next-state values.
//  - o_irq updates in the same cycle as the state change that causes it.
// TESTING
//  1. Reset, then push 8'hA5. Read addr1 -> 8'h01. Read addr0 -> 8'hA5.
//     Read addr1 -> 8'h00.
//  2. Push 8 bytes -> o_irq rises the cycle count reaches 8.
//     One DATA read -> o_irq falls.
//  3. Push 17 bytes 8'h00..8'h10 -> STATUS = 8'hB0 (overflow, full, count=16).
//     16 DATA reads return 8'h00..8'h0F. Write addr1 8'h80 -> overflow cleared.
//  4. With FIFO full, push and DATA read in the same cycle -> count stays 16,
//     overflow=0, output order preserved.
//  5. Push 1 byte, then idle TIMEOUT_CLKS clocks -> STATUS = 8'h41, o_irq=1.
//     One DATA read -> STATUS = 8'h00, o_irq=0.
//  6. Push 3 bytes, then write addr1 8'h01 together with a push -> count=0.
//     Assert i_reset mid-reception -> all outputs 0 and STATUS=8'h00.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// Receive controller between uart_rx and the CPU expansion-card bus. Incoming
// bytes are buffered in a FIFO. The CPU reads them through a DATA register and
// watches a STATUS register. A level interrupt is raised on any of these
// conditions: the fill level is reached, the FIFO has sat idle too long, or
// bytes have been lost to overflow.
//
// Ports
//   i_clk      system clock
//   i_reset    synchronous reset, active-high
//   i_rxValid  one-cycle strobe from uart_rx: byte received
//   i_rxData   received byte, valid with i_rxValid
//   i_addr     register select: 0 = DATA, 1 = STATUS (read) / CTRL (write)
//   i_read     one-cycle read strobe
//   i_write    one-cycle write strobe
//   i_wdata    write data (CTRL: bit 7 clears overflow, bit 0 flushes)
//   o_rdata    read data, registered, holds until the next read
//   o_irq      level interrupt to CPU, registered
//
// STATUS = {overflow, timeout, full, count[4:0]}
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int DEPTH        = 16,     // power of two, 2..16
  parameter int IRQ_LEVEL    = 8,      // 1..DEPTH
  parameter int TIMEOUT_CLKS = 34720   // idle clocks before the timeout flag
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rxValid,
  input  logic [7:0] i_rxData,
  input  logic       i_addr,
  input  logic       i_read,
  input  logic       i_write,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata,
  output logic       o_irq
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int IDLE_W = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [4:0]        CNT_FULL  = 5'(DEPTH);
  localparam logic [4:0]        CNT_IRQ   = 5'(IRQ_LEVEL);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CLKS);
  localparam logic [IDLE_W-1:0] IDLE_TRIG = IDLE_W'(TIMEOUT_CLKS - 1);

  // Storage and state
  logic [7:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [4:0]        r_count;
  logic              r_overflow;
  logic              r_timeout;
  logic [IDLE_W-1:0] r_idle;

  // Per-cycle decode
  logic       w_full;
  logic       w_empty;
  logic       w_rd_data;
  logic       w_rd_status;
  logic       w_ctrl_wr;
  logic       w_flush;
  logic       w_clr_ovf;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;
  logic [7:0] w_status;

  // Next-state values
  logic [4:0]        w_count_nxt;
  logic              w_overflow_nxt;
  logic              w_timeout_nxt;
  logic [IDLE_W-1:0] w_idle_nxt;

  // CTRL bits 6..1 have no function.
  logic w_unused;
  assign w_unused = ^i_wdata[6:1];

  assign w_full    = (r_count == CNT_FULL);
  assign w_empty   = (r_count == 5'd0);
  assign w_status  = {r_overflow, r_timeout, w_full, r_count};

  // A read and a write in the same cycle: the read wins, so the write is dropped.
  assign w_rd_data   = i_read & ~i_addr;
  assign w_rd_status = i_read &  i_addr;
  assign w_ctrl_wr   = i_write & ~i_read & i_addr;
  assign w_flush     = w_ctrl_wr & i_wdata[0];
  assign w_clr_ovf   = w_ctrl_wr & i_wdata[7];

  // A read of an empty FIFO returns zero. It does not pop, even when a push
  // lands in the same cycle.
  assign w_pop  = w_rd_data & ~w_empty;
  // A flush discards the byte arriving with it. A pop frees a slot in a full FIFO.
  assign w_push = i_rxValid & ~w_flush & (~w_full | w_pop);
  assign w_drop = i_rxValid & ~w_flush & w_full & ~w_pop;

  // NOTE: every always_comb output gets a default assignment first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    w_count_nxt    = r_count;
    w_overflow_nxt = r_overflow;
    w_timeout_nxt  = r_timeout;
    w_idle_nxt     = r_idle;

    if (w_flush) begin
      w_count_nxt = 5'd0;
    end else begin
      w_count_nxt = r_count + 5'(w_push) - 5'(w_pop);
    end

    // A clear and a drop in the same cycle leave overflow set. The drop is
    // the newer event.
    if (w_clr_ovf) begin
      w_overflow_nxt = 1'b0;
    end
    if (w_drop) begin
      w_overflow_nxt = 1'b1;
    end

    if (w_push || w_pop || w_flush || w_empty) begin
      w_idle_nxt = '0;
    end else if (r_idle != IDLE_MAX) begin
      w_idle_nxt = r_idle + IDLE_W'(1);
    end

    if (w_pop || w_flush) begin
      w_timeout_nxt = 1'b0;
    end else if ((w_count_nxt != 5'd0) && (w_idle_nxt >= IDLE_TRIG)) begin
      w_timeout_nxt = 1'b1;
    end
  end

  // NOTE: the FIFO RAM has no reset. Its contents are never read before being
  // written, and leaving it unreset keeps it mappable onto RAM primitives.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_rxData;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All next-state
  // decisions are then made on values from before the clock edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= 5'd0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
      r_idle     <= '0;
      o_rdata    <= 8'h00;
      o_irq      <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_overflow <= w_overflow_nxt;
      r_timeout  <= w_timeout_nxt;
      r_idle     <= w_idle_nxt;

      if (w_flush) begin
        r_rd_ptr <= r_wr_ptr;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
      end

      if (w_rd_data) begin
        o_rdata <= w_pop ? r_mem[r_rd_ptr] : 8'h00;
      end else if (w_rd_status) begin
        o_rdata <= w_status;
      end

      o_irq <= (w_count_nxt >= CNT_IRQ) | w_timeout_nxt | w_overflow_nxt;
    end
  end

endmodule
